// File: rtl/ram_32x4_write_sequencer.sv
// Write-port sequencer for the 32x4 dual-port RAM: manual writes, constant/incrementing fills, timed record.
// Optional input synchronizers are enabled by defining WRSEQ_INPUT_SYNC_EN.
module ram_32x4_write_sequencer #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              wr_req,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_RECORD = 2'd2;

    localparam logic [1:0] MODE_MANUAL     = 2'b00;
    localparam logic [1:0] MODE_FILL_CONST = 2'b01;
    localparam logic [1:0] MODE_FILL_INC   = 2'b10;
    localparam logic [1:0] MODE_RECORD     = 2'b11;

    logic              wr_req_s;
    logic              start_s;
    logic [DATA_W-1:0] data_s;

`ifdef WRSEQ_INPUT_SYNC_EN
    logic              wr_req_s1_q, wr_req_s2_q;
    logic              start_s1_q, start_s2_q;
    logic [DATA_W-1:0] data_s1_q, data_s2_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_req_s1_q <= 1'b0;
            wr_req_s2_q <= 1'b0;
            start_s1_q  <= 1'b0;
            start_s2_q  <= 1'b0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
        end else begin
            wr_req_s1_q <= wr_req;
            wr_req_s2_q <= wr_req_s1_q;
            start_s1_q  <= start;
            start_s2_q  <= start_s1_q;
            data_s1_q   <= data_in;
            data_s2_q   <= data_s1_q;
        end
    end

    assign wr_req_s = wr_req_s2_q;
    assign start_s  = start_s2_q;
    assign data_s   = data_s2_q;
`else
    assign wr_req_s = wr_req;
    assign start_s  = start;
    assign data_s   = data_in;
`endif

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              wr_req_dly_q, wr_req_dly_d;
    logic              start_dly_q, start_dly_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              wr_req_ev;
    logic              start_ev;
    logic [DATA_W-1:0] fill_data;

    assign wr_req_ev = wr_req_s & ~wr_req_dly_q;
    assign start_ev  = start_s & ~start_dly_q;
    // wr_ptr doubles as the fill index; its low bits form the incrementing offset
    assign fill_data = (mode_q == MODE_FILL_INC) ? seed_q + DATA_W'(wr_ptr_q) : seed_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        tick_d       = tick_q;
        wr_req_dly_d = wr_req_s;
        start_dly_d  = start_s;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        wr_ptr_d     = wr_ptr_q;
        busy_d       = busy_q;
        done_d       = done_q;

        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_MANUAL) begin
                    if (wr_req_ev) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = wr_ptr_q;
                        ram_data_d = data_s;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                    end
                end else if (start_ev) begin
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    wr_ptr_d = '0;
                    seed_d   = data_s;
                    mode_d   = mode;
                    tick_d   = '0;
                    state_d  = (mode == MODE_RECORD) ? ST_RECORD : ST_FILL;
                end
            end

            ST_FILL: begin
                ram_we_d   = 1'b1;
                ram_addr_d = wr_ptr_q;
                ram_data_d = fill_data;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                if (wr_ptr_q == LAST_ADDR) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    wr_ptr_d = '0;
                    state_d  = ST_IDLE;
                end
            end

            ST_RECORD: begin
                if (tick_q == TICK_LAST) begin
                    tick_d     = '0;
                    ram_we_d   = 1'b1;
                    ram_addr_d = wr_ptr_q;
                    ram_data_d = data_s;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_MANUAL;
            seed_q       <= '0;
            tick_q       <= '0;
            wr_req_dly_q <= 1'b0;
            start_dly_q  <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            wr_ptr_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            tick_q       <= tick_d;
            wr_req_dly_q <= wr_req_dly_d;
            start_dly_q  <= start_dly_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            wr_ptr_q     <= wr_ptr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign wr_ptr   = wr_ptr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ram_32x4_write_sequencer.sv
// Scoreboard bench for ram_32x4_write_sequencer: expected writes queued at stimulus, matched against observed writes.
module tb_ram_32x4_write_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] mode     = 2'b00;
    logic       wr_req   = 1'b0;
    logic       start    = 1'b0;
    logic [3:0] data_in  = 4'h0;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [3:0] ram_data;
    logic [4:0] wr_ptr;
    logic       busy;
    logic       done;

    ram_32x4_write_sequencer #(
        .ADDR_W  (5),
        .DATA_W  (4),
        .TICK_DIV(4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .mode    (mode),
        .wr_req  (wr_req),
        .start   (start),
        .data_in (data_in),
        .ram_we  (ram_we),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .wr_ptr  (wr_ptr),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [4:0]  addr;
        logic [3:0]  data;
        logic [31:0] cyc;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (ram_we === 1'b1) obs_q.push_back({ram_addr, ram_data, cyc});
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        #2;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if ({ram_we, ram_addr, ram_data, wr_ptr, busy, done} !== 17'h0) begin
            failures++;
            $display("FAIL reset_held got=%h required=0", {ram_we, ram_addr, ram_data, wr_ptr, busy, done});
        end
        reset = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        checks++;
        if ({ram_we, ram_addr, ram_data, wr_ptr, busy, done} !== 17'h0) begin
            failures++;
            $display("FAIL reset_released got=%h required=0", {ram_we, ram_addr, ram_data, wr_ptr, busy, done});
        end
        #2;
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_no_we got=%0d writes required=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_manual();
        wr_t e, o;
        int unsigned prev;
        mode    = 2'b00;
        data_in = 4'hA;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({5'(i), 4'hA, 32'd0});
            wr_req = 1'b1;
            @(negedge CLOCK_50);
            wr_req = 1'b0;
            @(negedge CLOCK_50);
        end
        checks++;
        if (wr_ptr !== 5'd3) begin
            failures++;
            $display("FAIL manual_ptr3 got=%0d required=3", wr_ptr);
        end
        exp_q.push_back({5'd3, 4'hA, 32'd0});
        wr_req = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        wr_req = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if (wr_ptr !== 5'd4) begin
            failures++;
            $display("FAIL manual_long_pulse_ptr got=%0d required=4", wr_ptr);
        end
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL manual_start_ignored busy=%b required=0", busy);
        end
        #2;
        prev = 0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL manual_wr missing got=none required=%0d/%h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if ({o.addr, o.data} !== {e.addr, e.data} || (i > 0 && o.cyc == prev + 1)) begin
                    failures++;
                    $display("FAIL manual_wr got=%0d/%h required=%0d/%h (single-cycle we)", o.addr, o.data, e.addr, e.data);
                end
                prev = o.cyc;
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL manual_extra got=%0d extra writes required=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_wrap();
        wr_t e, o;
        do_reset();
        mode = 2'b00;
        for (int i = 0; i < 33; i++) begin
            data_in = 4'(i);
            exp_q.push_back({5'(i), 4'(i), 32'd0});
            wr_req = 1'b1;
            @(negedge CLOCK_50);
            wr_req = 1'b0;
            @(negedge CLOCK_50);
        end
        checks++;
        if (wr_ptr !== 5'd1) begin
            failures++;
            $display("FAIL wrap_ptr got=%0d required=1", wr_ptr);
        end
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL wrap_wr missing got=none required=%0d/%h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if ({o.addr, o.data} !== {e.addr, e.data}) begin
                    failures++;
                    $display("FAIL wrap_wr got=%0d/%h required=%0d/%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_extra got=%0d extra writes required=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_fill();
        wr_t e, o;
        logic [3:0] seed;
        int unsigned start_cyc, busy_cnt, n;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            mode    = (pass == 0) ? 2'b10 : 2'b01;
            seed    = (pass == 0) ? 4'hE : 4'h3;
            data_in = seed;
            for (int i = 0; i < 32; i++)
                exp_q.push_back({5'(i), (pass == 0) ? 4'(seed + 4'(i)) : seed, 32'd0});
            @(negedge CLOCK_50);
            start = 1'b1;
            @(negedge CLOCK_50);
            start = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL fill_launch pass=%0d got busy=%b done=%b required busy=1 done=0", pass, busy, done);
            end
            start_cyc = cyc;
            busy_cnt  = 0;
            n         = 0;
            while (done !== 1'b1 && n < 200) begin
                busy_cnt += (busy === 1'b1) ? 1 : 0;
                if (n == 5) begin
                    wr_req = 1'b1; start = 1'b1; mode = 2'b00; data_in = 4'h0;
                end else if (n == 6) begin
                    wr_req = 1'b0; start = 1'b0;
                end
                @(negedge CLOCK_50);
                n++;
            end
            checks++;
            if (done !== 1'b1) begin
                failures++;
                $display("FAIL fill_timeout pass=%0d got done=%b required=1", pass, done);
            end
            checks++;
            if (busy_cnt != 32) begin
                failures++;
                $display("FAIL fill_busy_len pass=%0d got=%0d required=32", pass, busy_cnt);
            end
            checks++;
            if (busy !== 1'b0 || wr_ptr !== 5'd0) begin
                failures++;
                $display("FAIL fill_end pass=%0d got busy=%b ptr=%0d required busy=0 ptr=0", pass, busy, wr_ptr);
            end
            repeat (2) @(negedge CLOCK_50);
            #2;
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                checks++;
                if (obs_q.size() == 0) begin
                    failures++;
                    $display("FAIL fill_wr missing pass=%0d got=none required=%0d/%h", pass, e.addr, e.data);
                end else begin
                    o = obs_q.pop_front();
                    if ({o.addr, o.data} !== {e.addr, e.data} || o.cyc != start_cyc + 1 + i) begin
                        failures++;
                        $display("FAIL fill_wr pass=%0d got=%0d/%h@%0d required=%0d/%h@%0d", pass, o.addr, o.data,
                                 o.cyc, e.addr, e.data, start_cyc + 1 + i);
                    end
                end
            end
            checks++;
            if (obs_q.size() != 0) begin
                failures++;
                $display("FAIL fill_extra pass=%0d got=%0d extra writes required=0", pass, obs_q.size());
            end
            obs_q.delete();
            checks++;
            if (done !== 1'b1) begin
                failures++;
                $display("FAIL fill_done_sticky pass=%0d got=%b required=1", pass, done);
            end
        end
    endtask

    task automatic test_record();
        wr_t e, o;
        logic [3:0] v;
        int unsigned start_cyc, busy_cnt, n, k;
        do_reset();
        mode    = 2'b11;
        data_in = 4'h3;
        exp_q.push_back({5'd0, 4'h3, 32'd0});
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        start_cyc = cyc;
        busy_cnt  = 0;
        n         = 0;
        k         = 0;
        while (done !== 1'b1 && n < 400) begin
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            if (ram_we === 1'b1) begin
                k++;
                if (k < 32) begin
                    v = 4'((k * 7 + 3) & 15);
                    data_in = v;
                    exp_q.push_back({5'(k), v, 32'd0});
                end
                if (k == 5) mode = 2'b00;
                if (k == 10) begin wr_req = 1'b1; start = 1'b1; end
                if (k == 11) begin wr_req = 1'b0; start = 1'b0; end
            end
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL record_timeout got done=%b required=1", done);
        end
        checks++;
        if (busy_cnt != 128) begin
            failures++;
            $display("FAIL record_busy_len got=%0d required=128", busy_cnt);
        end
        repeat (2) @(negedge CLOCK_50);
        #2;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL record_wr missing got=none required=%0d/%h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if ({o.addr, o.data} !== {e.addr, e.data} || o.cyc != start_cyc + 4 * (i + 1)) begin
                    failures++;
                    $display("FAIL record_wr got=%0d/%h@%0d required=%0d/%h@%0d", o.addr, o.data, o.cyc,
                             e.addr, e.data, start_cyc + 4 * (i + 1));
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL record_extra got=%0d extra writes required=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_fill();
        wr_t e, o;
        int unsigned n;
        mode    = 2'b01;
        data_in = 4'h5;
        for (int i = 0; i <= 10; i++) exp_q.push_back({5'(i), 4'h5, 32'd0});
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        n = 0;
        while (!(ram_we === 1'b1 && ram_addr === 5'd10) && n < 60) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (ram_addr !== 5'd10) begin
            failures++;
            $display("FAIL midreset_reach got addr=%0d required=10", ram_addr);
        end
        reset = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if ({ram_we, wr_ptr, busy, done} !== 8'h0) begin
            failures++;
            $display("FAIL midreset_outputs got we=%b ptr=%0d busy=%b done=%b required all 0", ram_we, wr_ptr, busy, done);
        end
        reset = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle got busy=%b done=%b required 0/0", busy, done);
        end
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL midreset_wr missing got=none required=%0d/%h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if ({o.addr, o.data} !== {e.addr, e.data}) begin
                    failures++;
                    $display("FAIL midreset_wr got=%0d/%h required=%0d/%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_extra got=%0d writes after reset required=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_manual();
        test_wrap();
        test_fill();
        test_record();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_32x4_write_sequencer.md
Name: ram_32x4_write_sequencer

Overview:
Write-side driver for the 32x4 dual-port RAM: generates the write port (address, data, write enable) that the 1 s scanning reader consumes on the other port. Supports four modes:
- single manual writes from a key strobe, with an auto-incrementing pointer;
- a constant block fill;
- an incrementing-pattern fill;
- a timed record that samples switch data into successive addresses once per tick.
Sits between board switches/keys and the RAM write port; the pointer and status go to HEX/LED display.

Parameters:
ADDR_W, 5, RAM address width (depth = 2**ADDR_W = 32)
DATA_W, 4, RAM data width
TICK_DIV, 50000000, CLOCK_50 cycles per record-mode sample (1 s at 50 MHz)

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
mode  input  2  00 MANUAL, 01 FILL_CONST, 10 FILL_INC, 11 RECORD; sampled only in IDLE
wr_req  input  1  level from key (active-high after board inversion); each rising edge is one request
start  input  1  level; rising edge launches FILL_CONST / FILL_INC / RECORD
data_in  input  DATA_W  switch data (manual write value, fill seed, record sample)
ram_we  output  1  write enable to RAM write port, one-cycle pulses
ram_addr  output  ADDR_W  RAM write address
ram_data  output  DATA_W  RAM write data
wr_ptr  output  ADDR_W  next address to be written (display)
busy  output  1  high while a fill or record runs
done  output  1  sticky; set when a fill/record completes, cleared on next start edge or reset

Behaviour:
- Reset: state IDLE; all outputs 0 (ram_we, ram_addr, ram_data, wr_ptr, busy, done); tick counter 0; edge-detect history registers 0.
- Edge detection:
  - wr_req_d and start_d are registered copies.
  - An edge is input & ~input_d.
  - A level held high generates exactly one event.
- IDLE:
  - mode 00, wr_req edge: next cycle ram_we=1, ram_addr=wr_ptr, ram_data=data_in (value at edge cycle); wr_ptr increments mod 32 (31 -> 0 wrap).
  - mode 01/10/11, start edge: done<=0, busy<=1, wr_ptr<=0, seed<=data_in; go to FILL or RECORD.
  - wr_req edges are ignored in non-manual modes; start edges are ignored in mode 00.
- FILL (modes 01/10):
  - One write per cycle, addresses 0..31, with ram_we high for 32 consecutive cycles.
  - Data = seed (01), or (seed + index) mod 16 (10), 4-bit wrap.
  - After the write to 31: busy<=0, done<=1, wr_ptr<=0, back to IDLE.
  - First write occurs 1 cycle after the start edge is detected.
- RECORD (mode 11):
  - Tick counter counts 0..TICK_DIV-1.
  - At terminal count: ram_we=1 for one cycle, ram_data=current data_in, ram_addr=wr_ptr; wr_ptr++.
  - First sample TICK_DIV cycles after entry.
  - After the write to 31: busy<=0, done<=1, IDLE.
- mode is latched at operation start; changes while busy have no effect.
- start or wr_req edges while busy are ignored (no restart).
- Reset mid-operation: immediate return to IDLE with all outputs 0; no further ram_we pulses.
- ram_we is never high for more than one cycle outside FILL; ram_addr/ram_data hold their last values when ram_we=0.

Optional Feature:
WRSEQ_INPUT_SYNC_EN
- Defined: wr_req, start and data_in pass through 2-flop synchronizers before edge detection/sampling, adding 2 cycles of latency to every response above.
- Undefined: inputs are used directly (caller guarantees synchronous inputs); latencies as stated.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0, state IDLE, no ram_we.
2. mode=00, data_in=0xA, three wr_req pulses -> writes (addr 0,0xA), (1,0xA), (2,0xA), each ram_we 1 cycle; wr_ptr=3; a 10-cycle-long pulse yields only one write.
3. mode=00, 33 wr_req pulses with data_in=index[3:0] -> address 31 written with 0xF, then wrap: 33rd write to address 0 with 0x0; wr_ptr=1.
4. mode=10, data_in=0xE, start pulse -> 32 consecutive ram_we cycles, addr 0..31, data 0xE,0xF,0x0,0x1,...; busy high for 32 cycles; done=1 after; a second start edge clears done.
5. TICK_DIV=4, mode=11, data_in stepping per tick -> writes every 4 cycles to addr 0..31 with the sampled values; mode changed to 00 mid-record has no effect; done after 128 cycles.
6. Reset asserted during FILL at addr 10 -> ram_we low from the next cycle, wr_ptr=0, busy=0, done=0.
